// File: rtl/conv_window_feeder.sv
// ---------------------------------------------------------------------------
// conv_window_feeder
//
// Source side of the 3x3 convolution input interface. Collects nine weight
// bytes, presents them once with a one-cycle weight_valid pulse, then
// streams a raster-order frame and emits every fully-populated 3x3 window
// (no padding) to the Convolution block.
//
// Parameters
//   IMG_W, IMG_H   image width / height in pixels (each >= 3)
//
// Ports
//   clk            single clock, rising edge
//   rst_n          synchronous active-low reset
//   w_valid/w_data serial weight stream, k-th accepted byte -> In_Weight_k
//   pix_valid/pix_data/pix_ready
//                  raster pixel stream, accepted on pix_valid && pix_ready
//   weight_valid   one-cycle pulse, In_Weight_1..9 valid
//   In_Weight_1..9 loaded weights, held until reload or reset
//   in_valid       In_IFM_1..9 hold a valid window this cycle
//   In_IFM_1..9    window in row-major order (1..3 top, 7..9 bottom)
//   frame_done     pulse together with the last window of a frame
// ---------------------------------------------------------------------------
module conv_window_feeder #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       w_valid,
    input  logic [7:0] w_data,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    output logic       pix_ready,
    output logic       weight_valid,
    output logic [7:0] In_Weight_1,
    output logic [7:0] In_Weight_2,
    output logic [7:0] In_Weight_3,
    output logic [7:0] In_Weight_4,
    output logic [7:0] In_Weight_5,
    output logic [7:0] In_Weight_6,
    output logic [7:0] In_Weight_7,
    output logic [7:0] In_Weight_8,
    output logic [7:0] In_Weight_9,
    output logic       in_valid,
    output logic [7:0] In_IFM_1,
    output logic [7:0] In_IFM_2,
    output logic [7:0] In_IFM_3,
    output logic [7:0] In_IFM_4,
    output logic [7:0] In_IFM_5,
    output logic [7:0] In_IFM_6,
    output logic [7:0] In_IFM_7,
    output logic [7:0] In_IFM_8,
    output logic [7:0] In_IFM_9,
    output logic       frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {
        S_WLOAD  = 2'd0,
        S_WOUT   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    // Control state and counters
    state_t          state_r;
    state_t          state_nx_s;
    logic [3:0]      wcnt_r;
    logic [CW-1:0]   col_r;
    logic [RW-1:0]   row_r;

    // Weight storage
    logic [7:0]      weight_r [0:8];

    // Line buffers: lb1 holds row r-1, lb2 holds row r-2
    logic [7:0]      lb1_r [0:IMG_W-1];
    logic [7:0]      lb2_r [0:IMG_W-1];

    // Shift window: columns c-2 (index 0) and c-1 (index 1). The third
    // column is the one arriving with the current pixel, so it is taken
    // straight from the line buffers and pix_data when the window is
    // captured into the output registers.
    logic [7:0]      win_top_r [0:1];
    logic [7:0]      win_mid_r [0:1];
    logic [7:0]      win_bot_r [0:1];

    // Decoded controls
    logic            w_load_s;
    logic            accept_s;
    logic            last_col_s;
    logic            last_pix_s;
    logic            emit_s;
    logic [7:0]      new_top_s;
    logic [7:0]      new_mid_s;

    // Output registers
    logic            pix_ready_r;
    logic            weight_valid_r;
    logic            in_valid_r;
    logic            frame_done_r;
    logic [7:0]      ifm_r [0:8];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_WLOAD;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_WLOAD: begin
                if (w_valid && (wcnt_r == 4'd8)) begin
                    state_nx_s = S_WOUT;
                end else begin
                    state_nx_s = S_WLOAD;
                end
            end
            S_WOUT: begin
                state_nx_s = S_STREAM;
            end
            S_STREAM: begin
                if (pix_valid && (row_r == ROW_LAST) && (col_r == COL_LAST)) begin
                    state_nx_s = S_WLOAD;
                end else begin
                    state_nx_s = S_STREAM;
                end
            end
            default: begin
                state_nx_s = S_WLOAD;
            end
        endcase
    end

    // Output / datapath control decode from the current state
    always_comb begin
        w_load_s   = 1'b0;
        accept_s   = 1'b0;
        case (state_r)
            S_WLOAD: begin
                w_load_s = w_valid;
            end
            S_WOUT: begin
                w_load_s = 1'b0;
            end
            S_STREAM: begin
                accept_s = pix_valid;
            end
            default: begin
                w_load_s = 1'b0;
                accept_s = 1'b0;
            end
        endcase

        last_col_s = (col_r == COL_LAST);
        last_pix_s = last_col_s && (row_r == ROW_LAST);

        // Window is complete only once two earlier rows and two earlier
        // columns of the current row are available.
        if (accept_s && (row_r >= ROW_TWO) && (col_r >= COL_TWO)) begin
            emit_s = 1'b1;
        end else begin
            emit_s = 1'b0;
        end

        new_top_s = lb2_r[col_r];
        new_mid_s = lb1_r[col_r];
    end

    // Weight counter and pixel position counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt_r <= 4'd0;
            col_r  <= '0;
            row_r  <= '0;
        end else begin
            case (state_r)
                S_WLOAD: begin
                    if (w_load_s) begin
                        wcnt_r <= wcnt_r + 4'd1;
                    end
                end
                S_WOUT: begin
                    wcnt_r <= wcnt_r;
                end
                S_STREAM: begin
                    if (accept_s) begin
                        if (last_pix_s) begin
                            wcnt_r <= 4'd0;
                            col_r  <= '0;
                            row_r  <= '0;
                        end else if (last_col_s) begin
                            col_r  <= '0;
                            row_r  <= row_r + RW'(1);
                        end else begin
                            col_r  <= col_r + CW'(1);
                        end
                    end
                end
                default: begin
                    wcnt_r <= 4'd0;
                    col_r  <= '0;
                    row_r  <= '0;
                end
            endcase
        end
    end

    // Weight slots, written one per accepted weight byte
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                weight_r[i] <= 8'd0;
            end
        end else if (w_load_s) begin
            weight_r[wcnt_r] <= w_data;
        end
    end

    // Line buffers: age the column at col by one row on every accepted pixel.
    // Contents are only read after being rewritten in the current frame, so
    // they carry no reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb2_r[col_r] <= lb1_r[col_r];
            lb1_r[col_r] <= pix_data;
        end
    end

    // Shift window: push the arriving column in, drop the oldest
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                win_top_r[i] <= 8'd0;
                win_mid_r[i] <= 8'd0;
                win_bot_r[i] <= 8'd0;
            end
        end else if (accept_s) begin
            win_top_r[0] <= win_top_r[1];
            win_mid_r[0] <= win_mid_r[1];
            win_bot_r[0] <= win_bot_r[1];
            win_top_r[1] <= new_top_s;
            win_mid_r[1] <= new_mid_s;
            win_bot_r[1] <= pix_data;
        end
    end

    // Registered outputs; handshake flags follow the upcoming state so they
    // line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_ready_r    <= 1'b0;
            weight_valid_r <= 1'b0;
            in_valid_r     <= 1'b0;
            frame_done_r   <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                ifm_r[i] <= 8'd0;
            end
        end else begin
            pix_ready_r    <= (state_nx_s == S_STREAM);
            weight_valid_r <= (state_nx_s == S_WOUT);
            in_valid_r     <= emit_s;
            frame_done_r   <= accept_s && last_pix_s;
            if (emit_s) begin
                ifm_r[0] <= win_top_r[0];
                ifm_r[1] <= win_top_r[1];
                ifm_r[2] <= new_top_s;
                ifm_r[3] <= win_mid_r[0];
                ifm_r[4] <= win_mid_r[1];
                ifm_r[5] <= new_mid_s;
                ifm_r[6] <= win_bot_r[0];
                ifm_r[7] <= win_bot_r[1];
                ifm_r[8] <= pix_data;
            end
        end
    end

    assign pix_ready    = pix_ready_r;
    assign weight_valid = weight_valid_r;
    assign in_valid     = in_valid_r;
    assign frame_done   = frame_done_r;

    assign In_Weight_1  = weight_r[0];
    assign In_Weight_2  = weight_r[1];
    assign In_Weight_3  = weight_r[2];
    assign In_Weight_4  = weight_r[3];
    assign In_Weight_5  = weight_r[4];
    assign In_Weight_6  = weight_r[5];
    assign In_Weight_7  = weight_r[6];
    assign In_Weight_8  = weight_r[7];
    assign In_Weight_9  = weight_r[8];

    assign In_IFM_1     = ifm_r[0];
    assign In_IFM_2     = ifm_r[1];
    assign In_IFM_3     = ifm_r[2];
    assign In_IFM_4     = ifm_r[3];
    assign In_IFM_5     = ifm_r[4];
    assign In_IFM_6     = ifm_r[5];
    assign In_IFM_7     = ifm_r[6];
    assign In_IFM_8     = ifm_r[7];
    assign In_IFM_9     = ifm_r[8];

endmodule

// File: tb/tb_conv_window_feeder.sv
// ---------------------------------------------------------------------------
// Testbench for conv_window_feeder (4x4 image). Stimulus pushes expected
// window / weight responses into queues; a negedge monitor pops and compares
// whenever the DUT raises in_valid or weight_valid.
// ---------------------------------------------------------------------------
module tb_conv_window_feeder;

    localparam int W = 4;
    localparam int H = 4;

    // Hand-computed windows for pixels 0..15 on a 4x4 image
    localparam logic [71:0] EXP_W0 = {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
    localparam logic [71:0] EXP_W1 = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
    localparam logic [71:0] EXP_W2 = {8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14};
    localparam logic [71:0] EXP_W3 = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};

    // Weight sets (In_Weight_1 in the top byte)
    localparam logic [71:0] WT_A = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    localparam logic [71:0] WT_B = {8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18, 8'd19};
    localparam logic [71:0] WT_C = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       w_valid;
    logic [7:0] w_data;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_ready;
    logic       weight_valid;
    logic [7:0] In_Weight_1, In_Weight_2, In_Weight_3, In_Weight_4, In_Weight_5;
    logic [7:0] In_Weight_6, In_Weight_7, In_Weight_8, In_Weight_9;
    logic       in_valid;
    logic [7:0] In_IFM_1, In_IFM_2, In_IFM_3, In_IFM_4, In_IFM_5;
    logic [7:0] In_IFM_6, In_IFM_7, In_IFM_8, In_IFM_9;
    logic       frame_done;

    logic [71:0] ifm_bus;
    logic [71:0] wgt_bus;
    assign ifm_bus = {In_IFM_1, In_IFM_2, In_IFM_3, In_IFM_4, In_IFM_5,
                      In_IFM_6, In_IFM_7, In_IFM_8, In_IFM_9};
    assign wgt_bus = {In_Weight_1, In_Weight_2, In_Weight_3, In_Weight_4, In_Weight_5,
                      In_Weight_6, In_Weight_7, In_Weight_8, In_Weight_9};

    typedef struct packed {
        logic [71:0] win;
        logic        fd;
        logic [31:0] cyc;
    } win_exp_t;

    typedef struct packed {
        logic [71:0] w;
        logic [31:0] cyc;
    } wt_exp_t;

    win_exp_t win_q[$];
    wt_exp_t  wt_q[$];
    win_exp_t win_e;
    wt_exp_t  wt_e;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    conv_window_feeder #(.IMG_W(W), .IMG_H(H)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .w_valid      (w_valid),
        .w_data       (w_data),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_ready    (pix_ready),
        .weight_valid (weight_valid),
        .In_Weight_1  (In_Weight_1),
        .In_Weight_2  (In_Weight_2),
        .In_Weight_3  (In_Weight_3),
        .In_Weight_4  (In_Weight_4),
        .In_Weight_5  (In_Weight_5),
        .In_Weight_6  (In_Weight_6),
        .In_Weight_7  (In_Weight_7),
        .In_Weight_8  (In_Weight_8),
        .In_Weight_9  (In_Weight_9),
        .in_valid     (in_valid),
        .In_IFM_1     (In_IFM_1),
        .In_IFM_2     (In_IFM_2),
        .In_IFM_3     (In_IFM_3),
        .In_IFM_4     (In_IFM_4),
        .In_IFM_5     (In_IFM_5),
        .In_IFM_6     (In_IFM_6),
        .In_IFM_7     (In_IFM_7),
        .In_IFM_8     (In_IFM_8),
        .In_IFM_9     (In_IFM_9),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pix_ready"},    72'(pix_ready),    72'd0);
        chk({tag, "_weight_valid"}, 72'(weight_valid), 72'd0);
        chk({tag, "_in_valid"},     72'(in_valid),     72'd0);
        chk({tag, "_frame_done"},   72'(frame_done),   72'd0);
        chk({tag, "_ifm"},          ifm_bus,           72'd0);
        chk({tag, "_weights"},      wgt_bus,           72'd0);
    endtask

    // Monitor: pop expected responses whenever the DUT presents one
    always @(negedge clk) begin
        if (in_valid === 1'b1 && weight_valid === 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL overlap: in_valid and weight_valid both 1 at cycle %0d", cyc);
        end
        if (in_valid === 1'b1) begin
            if (win_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_window: got %h expected none", ifm_bus);
            end else begin
                win_e = win_q.pop_front();
                chk("window",       ifm_bus,          win_e.win);
                chk("frame_done",   72'(frame_done),  72'(win_e.fd));
                chk("window_cycle", 72'(cyc),         72'(win_e.cyc));
            end
        end else if (frame_done === 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL stray_frame_done: got 1 expected 0 at cycle %0d", cyc);
        end
        if (weight_valid === 1'b1) begin
            if (wt_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_weight_valid: got 1 expected 0 at cycle %0d", cyc);
            end else begin
                wt_e = wt_q.pop_front();
                chk("weights",      wgt_bus,   wt_e.w);
                chk("weight_cycle", 72'(cyc),  72'(wt_e.cyc));
            end
        end
    end

    // All tasks below start and end at posedge + 1
    task automatic load_weights(input logic [71:0] w, input bit gap);
        wt_exp_t e;
        for (int k = 0; k < 9; k++) begin
            w_valid = 1'b1;
            w_data  = w[71 - 8*k -: 8];
            @(posedge clk);
            #1;
            w_valid = 1'b0;
            if (k == 8) begin
                e.w   = w;
                e.cyc = 32'(cyc);
                wt_q.push_back(e);
            end
            if (gap && k == 3) begin
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        @(negedge clk);
        chk("pix_ready_in_wout", 72'(pix_ready), 72'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("pix_ready_after_wout", 72'(pix_ready), 72'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [7:0] v, output bit ok);
        bit acc;
        pix_valid = 1'b1;
        pix_data  = v;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            acc = pix_ready;
            @(posedge clk);
            #1;
            ok = acc;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL pix_accept: pixel %0d not accepted within 20 cycles", v);
        end
    endtask

    task automatic push_win(input logic [71:0] win, input logic fd);
        win_exp_t e;
        e.win = win;
        e.fd  = fd;
        e.cyc = 32'(cyc);
        win_q.push_back(e);
    endtask

    task automatic send_frame(input int n, input bit thr, input bit junk);
        bit ok;
        if (junk) begin
            w_valid = 1'b1;
            w_data  = 8'hFF;
        end
        for (int i = 0; i < n; i++) begin
            if (junk && i == n - 1) w_valid = 1'b0;
            send_pixel(8'(i), ok);
            if (ok) begin
                case (i)
                    10:      push_win(EXP_W0, 1'b0);
                    11:      push_win(EXP_W1, 1'b0);
                    14:      push_win(EXP_W2, 1'b0);
                    15:      push_win(EXP_W3, 1'b1);
                    default: ;
                endcase
            end
            if (thr && i < n - 1) begin
                pix_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        pix_valid = 1'b0;
        w_valid   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        w_valid   = 1'b0;
        w_data    = 8'd0;
        pix_valid = 1'b0;
        pix_data  = 8'd0;

        // 1. Reset with random inputs
        repeat (3) begin
            w_valid   = 1'($urandom_range(0, 1));
            w_data    = 8'($urandom);
            pix_valid = 1'($urandom_range(0, 1));
            pix_data  = 8'($urandom);
            @(posedge clk);
            #1;
            @(negedge clk);
            check_zero("reset");
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        w_valid   = 1'b0;
        pix_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_pix_ready",    72'(pix_ready),    72'd0);
            chk("idle_weight_valid", 72'(weight_valid), 72'd0);
            @(posedge clk);
            #1;
        end

        // 2. Weight load with a gap after weight 4
        load_weights(WT_A, 1'b1);

        // 3. Basic frame, back-to-back pixels
        send_frame(16, 1'b0, 1'b0);

        // 4. Throttled source, same frame
        load_weights(WT_A, 1'b0);
        send_frame(16, 1'b1, 1'b0);

        // 5. Pixels offered while loading weights are not consumed
        pix_valid = 1'b1;
        pix_data  = 8'hAA;
        repeat (3) begin
            @(negedge clk);
            chk("wload_pix_ready", 72'(pix_ready), 72'd0);
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
        load_weights(WT_B, 1'b0);
        // Weight writes during streaming are ignored
        send_frame(16, 1'b0, 1'b1);
        @(negedge clk);
        chk("weights_after_junk", wgt_bus, WT_B);
        @(posedge clk);
        #1;

        // 6. Mid-frame reset, then a fresh load and frame
        load_weights(WT_A, 1'b0);
        send_frame(7, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_zero("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        load_weights(WT_C, 1'b0);
        chk("weight1_after_reload", 72'(In_Weight_1), 72'd9);
        send_frame(16, 1'b0, 1'b0);

        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("windows_left", 72'(win_q.size()), 72'd0);
        chk("weights_left", 72'(wt_q.size()),  72'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_window_feeder.md
# conv_window_feeder

Source side of the convolution input interface: drives `in_valid`, `weight_valid`, `In_IFM_1..9` and `In_Weight_1..9` exactly as the 3x3 Convolution block consumes them. Accepts a serial 8-bit weight stream and a raster-order 8-bit pixel stream. Buffers two image rows and emits one 3x3 window per valid output position, with no padding. Sits between the frame source and `Convolution`, replacing the bench pattern generator in the integrated datapath.

## Interface
- `IMG_W`, 8: image width in pixels, at least 3.
- `IMG_H`, 8: image height in pixels, at least 3.

- `clk` input 1: single clock, all logic on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `w_valid` input 1: `w_data` carries a weight this cycle.
- `w_data` input 8: weight byte; the k-th accepted byte becomes `In_Weight_k`.
- `pix_valid` input 1: `pix_data` is offered.
- `pix_data` input 8: unsigned pixel in raster order (row-major, left to right).
- `pix_ready` output 1: feeder accepts a pixel. A pixel is accepted when `pix_valid && pix_ready`.
- `weight_valid` output 1: one-cycle pulse; `In_Weight_1..9` are valid.
- `In_Weight_1..9` output 8 each: weights, held stable after loading until the next reload or reset.
- `in_valid` output 1: `In_IFM_1..9` form a valid window this cycle.
- `In_IFM_1..9` output 8 each: window in row-major order. 1..3 are the top row, 4..6 the middle row, 7..9 the bottom row, each left to right.
- `frame_done` output 1: one-cycle pulse on the cycle of the last window of a frame.

## Operation
- **State machine:** `S_WLOAD` → `S_WOUT` → `S_STREAM` → `S_WLOAD`.
  - `S_WLOAD`: `pix_ready`=0. Each `w_valid` stores `w_data` into weight slot `wcnt` (0..8) and increments `wcnt`. Accepting the 9th weight moves to `S_WOUT`.
  - `S_WOUT`: lasts one cycle, with `weight_valid`=1. Goes to `S_STREAM`.
  - `S_STREAM`: `pix_ready`=1. `w_valid` is ignored. After accepting pixel IMG_W*IMG_H-1, goes to `S_WLOAD`. `wcnt`, row and column counters are cleared. Weights must be reloaded for every frame.
- **Counters:** `col` runs 0..IMG_W-1 and `row` runs 0..IMG_H-1. Both advance only on an accepted pixel. `col` wraps to 0 and `row` increments at end of line.
- **Buffering:**
  - Two line buffers of IMG_W bytes hold rows r-1 and r-2.
  - A 3x3 shift window takes, on each accepted pixel, the column {linebuf2[col], linebuf1[col], pix_data}.
  - The line buffers are then updated at `col`.
- **Window emission:** on accepting pixel (r,c) with r≥2 and c≥2, the window covering rows r-2..r and cols c-2..c is registered to `In_IFM_1..9` with `in_valid`=1 on the next cycle.
  - Windows never straddle a row wrap. Columns 0 and 1 of every row emit nothing.
  - The feeder emits (IMG_W-2)*(IMG_H-2) windows per frame.
- **Hold behaviour:** `In_IFM_*` hold their last value when `in_valid`=0. No arithmetic is performed; all data are 8-bit pass-through.
- **Ignored inputs:**
  - `pix_valid` is ignored outside `S_STREAM`, because `pix_ready`=0 there.
  - `w_valid` is ignored outside `S_WLOAD`.

## Timing
- **Reset:** when `rst_n`=0 at a clock edge, on the next cycle:
  - all outputs are 0, including `In_IFM_*`, `In_Weight_*` and `pix_ready`;
  - the state is `S_WLOAD`;
  - all counters are 0.
  - Reset mid-load or mid-frame discards everything; the line buffers need no clear.
- **Weight-load latency:** 9th weight accepted at cycle t → `weight_valid`=1 at t+1 → `pix_ready`=1 from t+2.
- **Window latency:** one cycle from accepting the window-completing pixel to `in_valid`.
  - With back-to-back pixels, `in_valid` is high on consecutive cycles within a row.
  - Source gaps appear as `in_valid` gaps.
- **Frame end:**
  - `frame_done` coincides with the final `in_valid`, one cycle after the last pixel is accepted.
  - `pix_ready` drops in that same cycle because the state is back in `S_WLOAD`.
- `weight_valid` and `in_valid` are never high in the same cycle.

## Test plan
1. **Reset:** hold `rst_n`=0 for 3 cycles with random inputs → every output is 0 and `pix_ready`=0. Then release → still idle, with no `weight_valid`.
2. **Weight load:** send weights 1..9 with a 2-cycle gap after weight 4 → exactly one `weight_valid` pulse, one cycle after weight 9, with `In_Weight_k`=k. `pix_ready`=1 on the following cycle.
3. **Basic frame:** IMG_W=IMG_H=4, pixels 0..15 back-to-back → four `in_valid` cycles, with `frame_done` on the last one:
   - after pixel 10: 0,1,2,4,5,6,8,9,10
   - after pixel 11: 1,2,3,5,6,7,9,10,11
   - after pixel 14: 4,5,6,8,9,10,12,13,14
   - after pixel 15: 5,6,7,9,10,11,13,14,15
4. **Throttled source:** same frame as test 3 with `pix_valid` toggling every cycle → identical window values. Each `in_valid` occurs exactly one cycle after the accepting edge.
5. **Ignored inputs:** pixels offered during `S_WLOAD` → not consumed. `w_valid`=1 with `w_data`=0xFF during `S_STREAM` → weights unchanged.
6. **Mid-frame reset:** pulse reset after 7 pixels → outputs return to 0. A fresh load of weights 9..1 plus a full frame of pixels 0..15 → windows exactly as in test 3, with `In_Weight_1`=9.
